// File: rtl/imem_loader.sv
// imem_loader: writable instruction memory filled from a valid/ready byte
// stream. Program bytes are stored little-endian from address 0. The rest of
// the memory is padded with RV32I NOPs (0x00000013). The core is held in
// reset until the load completes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start; core held
// LOAD   | accepting program bytes from the stream
// FILL   | padding the remaining bytes, one per cycle
// DONE   | memory valid, core released
// ERR    | program overflowed memory without a terminator; core held
module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   load_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] wptr_nxt;
    logic [ADDR_W:0]   count_nxt;
    // Word index is kept at full ADDR_W width so ADDR_W == 2 still works.
    logic [ADDR_W-1:0] last_word;
    logic [ADDR_W-1:0] last_word_nxt;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              accept;

    logic [7:0] mem [DEPTH];

    assign accept = in_valid && (state == S_LOAD);

    // Next-state, pointer/count updates and the memory write request.
    always_comb begin
        state_nxt     = state;
        wptr_nxt      = wptr;
        count_nxt     = load_count;
        last_word_nxt = last_word;
        wr_en         = 1'b0;
        wr_data       = in_data;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    wptr_nxt  = '0;
                    count_nxt = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en     = 1'b1;
                    wr_data   = in_data;
                    wptr_nxt  = wptr + ADDR_W'(1);
                    count_nxt = load_count + (ADDR_W+1)'(1);
                    if (in_last) begin
                        if (wptr == TOP_ADDR) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt     = S_FILL;
                            last_word_nxt = wptr >> 2;
                        end
                    end else if (wptr == TOP_ADDR) begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_FILL: begin
                wr_en    = 1'b1;
                wptr_nxt = wptr + ADDR_W'(1);
                // Bytes sharing a word with the last program byte are zeroed
                // so that partial word is not mistaken for a NOP opcode.
                if ((wptr >> 2) == last_word) begin
                    wr_data = 8'h00;
                end else if (wptr[1:0] == 2'd0) begin
                    wr_data = 8'h13;
                end else begin
                    wr_data = 8'h00;
                end
                if (wptr == TOP_ADDR) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            load_count <= '0;
            last_word  <= '0;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr_nxt;
            load_count <= count_nxt;
            last_word  <= last_word_nxt;
        end
    end

    // Byte memory; reset fills every word with a NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i[1:0] == 2'd0) ? 8'h13 : 8'h00;
            end
        end else if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] ra3;

    // Little-endian word read; address arithmetic wraps at the memory size.
    always_comb begin
        ra1     = rd_addr + ADDR_W'(1);
        ra2     = rd_addr + ADDR_W'(2);
        ra3     = rd_addr + ADDR_W'(3);
        rd_data = {mem[ra3], mem[ra2], mem[ra1], mem[rd_addr]};
    end

    assign in_ready = (state == S_LOAD);
    assign cpu_hold = (state != S_DONE);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a byte-array reference model.
module tb_imem_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   load_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mm [DEPTH];

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mword(input int a);
        return {mm[(a+3)%DEPTH], mm[(a+2)%DEPTH], mm[(a+1)%DEPTH], mm[a%DEPTH]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mm[i] = (i % 4 == 0) ? 8'h13 : 8'h00;
    endtask

    // Program of L bytes; with a terminator the tail is NOP-padded, except
    // the word holding the last program byte, whose remaining bytes are 0.
    task automatic model_load(input bq_t q, input bit has_last);
        int n;
        n = (q.size() < DEPTH) ? q.size() : DEPTH;
        for (int i = 0; i < n; i++) mm[i] = q[i];
        if (has_last) begin
            for (int i = n; i < DEPTH; i++) begin
                if (i / 4 == (n - 1) / 4) mm[i] = 8'h00;
                else                      mm[i] = (i % 4 == 0) ? 8'h13 : 8'h00;
            end
        end
    endtask

    task automatic check_words(input string tag);
        int a;
        for (int w = 0; w < DEPTH; w += 4) begin
            rd_addr = w[AW-1:0];
            #1;
            check($sformatf("%s@%0d", tag, w), rd_data, mword(w));
        end
        for (int k = 0; k < 3; k++) begin
            a = int'($urandom_range(0, DEPTH-1));
            rd_addr = a[AW-1:0];
            #1;
            check($sformatf("%s@u%0d", tag, a), rd_data, mword(a));
        end
        tick();
    endtask

    // Asserts rst mid-cycle and checks outputs before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_rst_ready"}, in_ready, 0);
        check({tag, "_rst_hold"},  cpu_hold, 1);
        check({tag, "_rst_done"},  done, 0);
        check({tag, "_rst_err"},   err, 0);
        model_reset();
        rd_addr = '0;
        #1;
        check({tag, "_rst_word0"}, rd_data, 32'h0000_0013);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ready_after_start", in_ready, 1);
    endtask

    task automatic send(input bq_t q, input bit mark_last, input bit stall,
                        input int dup_start_at, output int edges);
        edges = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (stall && (i % 2 == 1)) begin
                in_valid = 1'b0;
                tick();
                edges++;
            end
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = mark_last && (i == q.size() - 1);
            start    = (i == dup_start_at);
            tick();
            edges++;
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int n);
        n = 0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 1);
    endtask

    task automatic run_load(input string tag, input bq_t q, input bit stall, input int dup_at);
        int e;
        int n;
        start_load();
        send(q, 1'b1, stall, dup_at, e);
        wait_done(2 * DEPTH, n);
        model_load(q, 1'b1);
        check({tag, "_count"}, load_count, q.size());
        check({tag, "_done"},  done, 1);
        check({tag, "_hold"},  cpu_hold, 0);
        check({tag, "_err"},   err, 0);
        check_words(tag);
    endtask

    initial begin
        bq_t prog;
        bq_t part;
        bq_t q;
        int  e;
        int  n;
        int  len;

        prog = '{8'h13, 8'h04, 8'h00, 8'h01, 8'h93, 8'h04, 8'h10, 8'h10,
                 8'h33, 8'h89, 8'h84, 8'h00};
        part = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        model_reset();
        check("reset_ready", in_ready, 0);
        check("reset_hold",  cpu_hold, 1);
        check("reset_done",  done, 0);
        check("reset_err",   err, 0);
        check("reset_count", load_count, 0);
        check_words("reset");

        // Bytes offered while idle are ignored.
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
        tick(); tick(); tick();
        check("idle_ready", in_ready, 0);
        check("idle_count", load_count, 0);
        in_valid = 1'b0; in_last = 1'b0;
        check_words("idle");

        // Aligned load with latency measurement.
        start_load();
        send(prog, 1'b1, 1'b0, -1, e);
        wait_done(2 * DEPTH, n);
        check("aligned_latency", e + n, DEPTH);
        model_load(prog, 1'b1);
        check("aligned_count", load_count, 12);
        check("aligned_done", done, 1);
        check("aligned_hold", cpu_hold, 0);
        rd_addr = 5'd0; #1;
        check("aligned_w0", rd_data, 32'h0100_0413);
        rd_addr = 5'd8; #1;
        check("aligned_w8", rd_data, 32'h0084_8933);
        rd_addr = 5'd30; #1;
        check("wrap_read30", rd_data, 32'h0413_0000);
        check_words("aligned");

        // Reset in DONE releases nothing and restores NOPs.
        async_reset("done");
        check_words("after_done_rst");

        run_load("partial", part, 1'b0, -1);
        rd_addr = 5'd4; #1;
        check("partial_w4", rd_data, 32'h0000_2211);
        tick();

        // Stalled stream plus a start during LOAD gives the aligned result.
        run_load("stall", prog, 1'b1, 4);

        // Overflow: 33 bytes without terminator.
        q = {};
        for (int i = 0; i < DEPTH + 1; i++) q.push_back(8'($urandom));
        start_load();
        send(q, 1'b0, 1'b0, -1, e);
        model_load(q, 1'b0);
        check("ovf_err",   err, 1);
        check("ovf_ready", in_ready, 0);
        check("ovf_hold",  cpu_hold, 1);
        check("ovf_done",  done, 0);
        check("ovf_count", load_count, DEPTH);
        check_words("ovf");
        run_load("after_ovf", part, 1'b0, -1);

        // Exactly full program with terminator: FILL skipped.
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
        start_load();
        send(q, 1'b1, 1'b0, -1, e);
        check("full_done_direct", done, 1);
        model_load(q, 1'b1);
        check("full_count", load_count, DEPTH);
        check_words("full");

        for (int t = 0; t < 6; t++) begin
            len = int'($urandom_range(1, DEPTH));
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            run_load($sformatf("rnd%0d", t), q, 1'($urandom_range(0, 1)), -1);
        end

        // Reset in the middle of FILL.
        start_load();
        q = '{8'h01, 8'h02, 8'h03};
        send(q, 1'b1, 1'b0, -1, e);
        tick(); tick(); tick();
        check("fill_busy", done, 0);
        async_reset("fill");
        check("fill_rst_ready", in_ready, 0);
        check("fill_rst_done",  done, 0);
        check("fill_rst_count", load_count, 0);
        check_words("fill_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-stream loader: the write-side counterpart to the core's read-only, byte-addressed instruction memory. It accepts a program as a valid/ready byte stream and stores the bytes little-endian from address 0. It pads the rest of the memory with RV32I NOPs and holds the CPU in reset until loading completes. The fetch port is a drop-in replacement for the instruction memory read: combinational 32-bit little-endian word read.

## Interface
- `ADDR_W`, default 5: byte address width; memory is 2^ADDR_W bytes (default 32); must be ≥ 2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE, ERR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  program byte.
- `in_last`  in  1  qualifies final byte of the program.
- `in_ready`  out  1  byte accepted on edge where `in_valid & in_ready`.
- `rd_addr`  in  ADDR_W  fetch byte address.
- `rd_data`  out  32  `{mem[a+3],mem[a+2],mem[a+1],mem[a]}`, indices mod 2^ADDR_W.
- `cpu_hold`  out  1  keeps core in reset while high.
- `done`  out  1  level; load finished, memory valid.
- `err`  out  1  level; program overflowed memory.
- `load_count`  out  ADDR_W+1  bytes accepted in the current/last load.

## Operation
- States: IDLE, LOAD, FILL, DONE, ERR. Registers: state, `wptr` (ADDR_W bits), `load_count`, `last_word` (index of word holding last loaded byte), byte array `mem`.
- Reset (async, immediate): state=IDLE, `wptr`=0, `load_count`=0, every word of `mem` = 0x00000013 (bytes 13,00,00,00). Outputs: `in_ready`=0, `cpu_hold`=1, `done`=0, `err`=0.
- `in_ready` = (state==LOAD), combinational from state only.
- `cpu_hold` = 0 only in DONE; 1 in all other states.
- `done` = (state==DONE). `err` = (state==ERR).
- IDLE/DONE/ERR with `start`=1 → LOAD. `wptr`←0 and `load_count`←0. Memory is not cleared.
- LOAD, accept: `mem[wptr]`←`in_data`, `wptr`++, `load_count`++. Then:
  - `in_last`=1 and `wptr`==2^ADDR_W−1 → DONE.
  - `in_last`=1 otherwise → FILL; `last_word`←`wptr[ADDR_W-1:2]`.
  - `in_last`=0 and `wptr`==2^ADDR_W−1 → ERR; memory full, no terminator.
  - Otherwise stay in LOAD.
- LOAD, no accept: no change. `start` is ignored in LOAD and FILL.
- FILL: one byte per cycle at `wptr`, then `wptr`++:
  - Value is 0x00 if `wptr[ADDR_W-1:2]`==`last_word` (completes the partial word).
  - Otherwise 0x13 when `wptr[1:0]`==0, else 0x00.
  - Writing address 2^ADDR_W−1 → DONE.
- Input bytes arriving outside LOAD are not accepted and have no effect.
- `rd_data` is purely combinational from `mem` and `rd_addr`. Reads are legal in every state and return current contents.

## Timing
- `start` sampled at edge T → `in_ready`=1 from T.
- Byte accepted at edge T → visible on `rd_data` after T; `load_count` updates at T.
- L bytes with `in_last` (L < 2^ADDR_W), no input stalls: LOAD lasts L cycles and FILL lasts 2^ADDR_W − L cycles. `done`=1 and `cpu_hold`=0 from the edge after the final fill write.
- L = 2^ADDR_W with `in_last` on the final byte: DONE directly; FILL is skipped.
- Overflow: `err` and `in_ready`=0 from the edge accepting byte 2^ADDR_W. `load_count`=2^ADDR_W, `cpu_hold` stays 1.
- `rst` during any state: outputs return to reset values without waiting for a clock edge. The partially loaded program is discarded.

## Test plan
- **Reset:** assert `rst` mid-cycle → immediately `cpu_hold`=1, `in_ready`=0, `done`=0, `err`=0. `rd_data`=0x00000013 at `rd_addr` 0,4,…,28.
- **Aligned load:** `start`, then bytes 13 04 00 01 93 04 10 10 33 89 84 00 with `in_last` on byte 12, no gaps. Required:
  - `rd_data`@0=0x01000413, @4=0x10100493, @8=0x00848933, @12…28=0x00000013.
  - `load_count`=12; `done` rises 32 cycles after first accept.
- **Partial word:** bytes AA BB CC DD 11 22 with last on 22 → @0=0xDDCCBBAA, @4=0x00002211, @8=0x00000013.
- **Stalls and ignored inputs:** `in_valid` toggling every other cycle gives the same result as the aligned-load case. `in_valid`=1 in IDLE is not accepted. A second `start` during LOAD is ignored and `load_count` keeps counting.
- **Overflow:** 33 bytes, no `in_last` → `err`=1 after byte 32, `load_count`=32, `in_ready`=0, `cpu_hold`=1. A following `start` clears `err` and reloads correctly.
- **Wrap read and mid-FILL reset:**
  - After the aligned-load case, `rd_addr`=30 → `{mem[1],mem[0],mem[31],mem[30]}`=0x04130000.
  - Assert `rst` during FILL → IDLE, all words 0x00000013.
